// File: rtl/quadrature_decoder.sv
// quadrature_decoder: decodes an asynchronous A/B quadrature encoder into
// count/direction strobes, an illegal-transition pulse and a wrapping position.
// Optional feature: define QUAD_GLITCH_FILTER_EN to add a third sample stage
// that only accepts a new {A,B} once two consecutive synchronized samples agree.
module quadrature_decoder #(
  parameter int EXPONENT = 4
) (
  input  logic                clock_pos,
  input  logic                reset_neg,
  input  logic                bit_a,
  input  logic                bit_b,
  input  logic                bit_clear,
  output logic                bit_up,
  output logic                bit_count,
  output logic                bit_error,
  output logic [EXPONENT-1:0] vector_position
);

  typedef enum logic {UNPRIMED = 1'b0, TRACK = 1'b1} state_t;
  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DOWN, STEP_ERR} step_t;

  localparam logic [EXPONENT-1:0] POS_ONE = EXPONENT'(1);

  // Number of TRACK cycles after priming during which P simply follows S.
  // The synchronizer was forced to 00 during reset, so until the input level
  // present at release has propagated through every sample stage, S is stale
  // and a comparison would report a bogus step or error.
`ifdef QUAD_GLITCH_FILTER_EN
  localparam logic [1:0] SETTLE = 2'd3;
`else
  localparam logic [1:0] SETTLE = 2'd2;
`endif

  logic [1:0] sync_p0;
  logic [1:0] sync_p1;
  logic [1:0] sample;
  logic       sample_ok;
  state_t     state;
  logic [1:0] prev;
  logic [1:0] settle;
  step_t      step;

  // Gray-code transition classifier: forward cycle 00->01->11->10->00.
  function automatic step_t classify(input logic [1:0] p, input logic [1:0] s);
    step_t r;
    case ({p, s})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: r = STEP_UP;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: r = STEP_DOWN;
      4'b0000, 4'b0101, 4'b1111, 4'b1010: r = STEP_NONE;
      default:                            r = STEP_ERR;
    endcase
    return r;
  endfunction

`ifdef QUAD_GLITCH_FILTER_EN
  logic [1:0] sync_p2;

  // Three-stage sampling of the asynchronous encoder channels.
  always_ff @(posedge clock_pos or negedge reset_neg) begin
    if (!reset_neg) begin
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
      sync_p2 <= 2'b00;
    end else begin
      sync_p0 <= {bit_a, bit_b};
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // A level is only trusted once it has been seen on two consecutive cycles.
  assign sample    = sync_p2;
  assign sample_ok = (sync_p1 == sync_p2);
`else
  // Two-flop synchronizer for the asynchronous encoder channels.
  always_ff @(posedge clock_pos or negedge reset_neg) begin
    if (!reset_neg) begin
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
    end else begin
      sync_p0 <= {bit_a, bit_b};
      sync_p1 <= sync_p0;
    end
  end

  assign sample    = sync_p1;
  assign sample_ok = 1'b1;
`endif

  assign step = classify(prev, sample);

  // Priming/tracking FSM with registered strobes, direction and position.
  always_ff @(posedge clock_pos or negedge reset_neg) begin
    if (!reset_neg) begin
      state           <= UNPRIMED;
      prev            <= 2'b00;
      settle          <= SETTLE;
      bit_up          <= 1'b1;
      bit_count       <= 1'b0;
      bit_error       <= 1'b0;
      vector_position <= '0;
    end else begin
      bit_count <= 1'b0;
      bit_error <= 1'b0;
      case (state)
        UNPRIMED: begin
          prev  <= sample;
          state <= TRACK;
        end
        TRACK: begin
          if (settle != 2'd0) begin
            prev   <= sample;
            settle <= settle - 2'd1;
          end else if (sample_ok) begin
            prev <= sample;
            case (step)
              STEP_UP: begin
                bit_count       <= 1'b1;
                bit_up          <= 1'b1;
                vector_position <= vector_position + POS_ONE;
              end
              STEP_DOWN: begin
                bit_count       <= 1'b1;
                bit_up          <= 1'b0;
                vector_position <= vector_position - POS_ONE;
              end
              STEP_ERR: begin
                bit_error <= 1'b1;
              end
              default: begin
              end
            endcase
          end
        end
        default: state <= UNPRIMED;
      endcase
      // Clear wins over a simultaneous step; the strobes above still report it.
      if (bit_clear) vector_position <= '0;
    end
  end

endmodule
